// File: rtl/intf_pack.sv
// intf_pack: packs a serial bit stream LSB-first into WIDTH-bit words,
// with one output holding register so the next word can fill while the
// current one waits for the consumer.
module intf_pack #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_data,
  input  logic             in_rdy,
  output logic             in_en,
  input  logic             z_en,
  output logic [WIDTH-1:0] z_data,
  output logic             z_rdy,
  output logic [CW-1:0]    fill
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] obuf_q, obuf_d;
  logic             ovalid_q, ovalid_d;

  logic             last_c;
  logic             room_c;
  logic [WIDTH-1:0] shifted_c;

  // Accept decision; in_en is forced low during reset so nothing upstream is consumed.
  always_comb begin
    last_c    = (cnt_q == CW'(WIDTH - 1));
    room_c    = !ovalid_q || z_en;
    in_en     = RST_N && in_rdy && (!last_c || room_c);
    shifted_c = {in_data, sr_q[WIDTH-1:1]};
  end

  // Next-state: shift in accepted bits, hand a completed word to obuf, retire dequeued words.
  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    obuf_d   = obuf_q;
    ovalid_d = ovalid_q;
    if (z_en && ovalid_q) begin
      ovalid_d = 1'b0;
    end
    if (in_en) begin
      if (last_c) begin
        obuf_d   = shifted_c;
        ovalid_d = 1'b1;
        cnt_d    = '0;
      end else begin
        sr_d  = shifted_c;
        cnt_d = CW'(cnt_q + 1'b1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      obuf_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      obuf_q   <= obuf_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign z_data = obuf_q;
  assign z_rdy  = ovalid_q;
  assign fill   = cnt_q;

endmodule

// File: tb/tb_intf_pack.sv
// Directed bench for intf_pack at WIDTH=8.
module tb_intf_pack;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_data;
  logic         in_rdy;
  logic         in_en;
  logic         z_en;
  logic [W-1:0] z_data;
  logic         z_rdy;
  logic [2:0]   fill;

  int n_cmp = 0;
  int n_err = 0;

  intf_pack #(.WIDTH(W)) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .in_data(in_data),
    .in_rdy (in_rdy),
    .in_en  (in_en),
    .z_en   (z_en),
    .z_data (z_data),
    .z_rdy  (z_rdy),
    .fill   (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_rdy = 1'b1; in_data = 1'b1; z_en = 1'b0;
    #1;
    n_cmp++; if (in_en !== 1'b0) begin n_err++; $display("FAIL reset_in_en0: got %b exp 0", in_en); end
    for (int c = 0; c < 2; c++) begin
      tick;
      n_cmp++; if (in_en !== 1'b0) begin n_err++; $display("FAIL reset_in_en: got %b exp 0", in_en); end
      n_cmp++; if (z_rdy !== 1'b0) begin n_err++; $display("FAIL reset_z_rdy: got %b exp 0", z_rdy); end
      n_cmp++; if (z_data !== 8'h00) begin n_err++; $display("FAIL reset_z_data: got %h exp 00", z_data); end
      n_cmp++; if (fill !== 3'd0) begin n_err++; $display("FAIL reset_fill: got %0d exp 0", fill); end
    end
    rst_n = 1'b1; in_rdy = 1'b0; in_data = 1'b0;
    tick;
  endtask

  task automatic test_single_word;
    logic [7:0] bits;
    bits = 8'h4D;  // LSB-first sequence 1,0,1,1,0,0,1,0
    z_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_rdy = 1'b1; in_data = bits[i];
      #1;
      n_cmp++; if (in_en !== 1'b1) begin n_err++; $display("FAIL single_in_en bit%0d: got %b exp 1", i, in_en); end
      tick;
      n_cmp++; if (fill !== 3'((i + 1) % 8)) begin n_err++; $display("FAIL single_fill bit%0d: got %0d exp %0d", i, fill, (i + 1) % 8); end
      if (i < 7) begin
        n_cmp++; if (z_rdy !== 1'b0) begin n_err++; $display("FAIL single_z_rdy_early bit%0d: got %b exp 0", i, z_rdy); end
      end
    end
    in_rdy = 1'b0;
    n_cmp++; if (z_rdy !== 1'b1) begin n_err++; $display("FAIL single_z_rdy: got %b exp 1", z_rdy); end
    n_cmp++; if (z_data !== 8'h4D) begin n_err++; $display("FAIL single_z_data: got %h exp 4d", z_data); end
    z_en = 1'b1;
    tick;
    z_en = 1'b0;
    n_cmp++; if (z_rdy !== 1'b0) begin n_err++; $display("FAIL single_dequeue: got %b exp 0", z_rdy); end
  endtask

  task automatic test_backpressure;
    z_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      in_rdy = 1'b1; in_data = (i < 8) ? 1'b1 : 1'b0;
      #1;
      n_cmp++; if (in_en !== 1'b1) begin n_err++; $display("FAIL bp_in_en bit%0d: got %b exp 1", i, in_en); end
      tick;
    end
    in_data = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (in_en !== 1'b0) begin n_err++; $display("FAIL bp_stall_in_en c%0d: got %b exp 0", c, in_en); end
      n_cmp++; if (fill !== 3'd7) begin n_err++; $display("FAIL bp_stall_fill c%0d: got %0d exp 7", c, fill); end
      n_cmp++; if (z_data !== 8'hFF) begin n_err++; $display("FAIL bp_stall_z_data c%0d: got %h exp ff", c, z_data); end
      n_cmp++; if (z_rdy !== 1'b1) begin n_err++; $display("FAIL bp_stall_z_rdy c%0d: got %b exp 1", c, z_rdy); end
      tick;
    end
    z_en = 1'b1;
    #1;
    n_cmp++; if (in_en !== 1'b1) begin n_err++; $display("FAIL bp_release_in_en: got %b exp 1", in_en); end
    tick;
    z_en = 1'b0; in_rdy = 1'b0;
    n_cmp++; if (z_rdy !== 1'b1) begin n_err++; $display("FAIL bp_swap_z_rdy: got %b exp 1", z_rdy); end
    n_cmp++; if (z_data !== 8'h00) begin n_err++; $display("FAIL bp_swap_z_data: got %h exp 00", z_data); end
    n_cmp++; if (fill !== 3'd0) begin n_err++; $display("FAIL bp_swap_fill: got %0d exp 0", fill); end
    z_en = 1'b1;
    tick;
    z_en = 1'b0;
  endtask

  task automatic test_streaming;
    logic [7:0] words [3];
    logic [7:0] got [3];
    logic [7:0] cur;
    int ng;
    int gaps;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h81;
    ng = 0; gaps = 0;
    for (int i = 0; i < 24; i++) begin
      cur = words[i / 8];
      in_rdy = 1'b1; in_data = cur[i % 8];
      z_en = z_rdy;
      #1;
      if (in_en !== 1'b1) gaps++;
      if (z_rdy === 1'b1 && ng < 3) begin got[ng] = z_data; ng++; end
      tick;
    end
    in_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      z_en = z_rdy;
      #1;
      if (z_rdy === 1'b1 && ng < 3) begin got[ng] = z_data; ng++; end
      tick;
    end
    z_en = 1'b0;
    n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL stream_gaps: got %0d exp 0", gaps); end
    n_cmp++; if (ng !== 3) begin n_err++; $display("FAIL stream_count: got %0d exp 3", ng); end
    for (int k = 0; k < 3; k++) begin
      if (k < ng) begin
        n_cmp++; if (got[k] !== words[k]) begin n_err++; $display("FAIL stream_word%0d: got %h exp %h", k, got[k], words[k]); end
      end
    end
  endtask

  task automatic test_reset_mid_word;
    logic [7:0] bits;
    bits = 8'h5A;
    z_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_rdy = 1'b1; in_data = 1'b1;
      tick;
    end
    n_cmp++; if (fill !== 3'd5) begin n_err++; $display("FAIL mid_fill_pre: got %0d exp 5", fill); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (in_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_in_en: got %b exp 0", in_en); end
    tick;
    rst_n = 1'b1;
    n_cmp++; if (fill !== 3'd0) begin n_err++; $display("FAIL mid_rst_fill: got %0d exp 0", fill); end
    for (int i = 0; i < 8; i++) begin
      in_rdy = 1'b1; in_data = bits[i];
      tick;
    end
    in_rdy = 1'b0;
    n_cmp++; if (z_rdy !== 1'b1) begin n_err++; $display("FAIL mid_z_rdy: got %b exp 1", z_rdy); end
    n_cmp++; if (z_data !== 8'h5A) begin n_err++; $display("FAIL mid_z_data: got %h exp 5a", z_data); end
    z_en = 1'b1;
    tick;
    z_en = 1'b0;
  endtask

  task automatic test_irregular;
    logic [7:0] bits;
    int idx;
    int cyc;
    int bad;
    bits = 8'hC3;
    idx = 0; cyc = 0; bad = 0;
    z_en = 1'b0;
    while (idx < 8 && cyc < 400) begin
      in_rdy = 1'($urandom_range(0, 1));
      in_data = bits[idx[2:0]];
      #1;
      if (in_en === 1'b1 && in_rdy !== 1'b1) bad++;
      if (in_en === 1'b1) idx++;
      tick;
      cyc++;
    end
    in_rdy = 1'b0;
    n_cmp++; if (idx !== 8) begin n_err++; $display("FAIL irr_timeout: got %0d bits exp 8", idx); end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL irr_in_en_without_rdy: got %0d exp 0", bad); end
    n_cmp++; if (z_rdy !== 1'b1) begin n_err++; $display("FAIL irr_z_rdy: got %b exp 1", z_rdy); end
    n_cmp++; if (z_data !== 8'hC3) begin n_err++; $display("FAIL irr_z_data: got %h exp c3", z_data); end
    z_en = 1'b1;
    tick;
    z_en = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_word;
    test_backpressure;
    test_streaming;
    test_reset_mid_word;
    test_irregular;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/intf_pack.md
# intf_pack

Serial-to-parallel packing stage that sits directly downstream of the 1-bit OR interface block. It pulls result bits through that block's actionvalue-style `y` handshake (`en`/`data`/`rdy`) and packs `WIDTH` consecutive bits LSB-first into one word. It offers each completed word through its own actionvalue method `z`. One output holding register lets the next word accumulate while the current word waits for the consumer.

## Interface
- `WIDTH`, default 8: bits per packed word; legal range 2..32.
- `CLK`  input  1  clock; all state updates on the rising edge.
- `RST_N`  input  1  reset; synchronous and active-low.
- `in_data`  input  1  upstream result bit; connects to upstream `y_data`.
- `in_rdy`  input  1  upstream has a bit available; connects to upstream `y_rdy`.
- `in_en`  output  1  dequeue strobe to upstream; connects to upstream `y_en`.
- `z_en`  input  1  downstream takes the current word this cycle; ignored when `z_rdy`=0.
- `z_data`  output  WIDTH  packed word.
- `z_rdy`  output  1  `z_data` holds a valid word.
- `fill`  output  clog2(WIDTH)  number of bits currently held in the partial word.

## Operation
- State:
  - shift register `sr[WIDTH-1:0]`;
  - bit counter `cnt`, range 0..WIDTH-1, exported as `fill`;
  - output register `obuf[WIDTH-1:0]` with valid flag `ovalid`.
- `z_data`=`obuf`. `z_rdy`=`ovalid`.
- Completion condition: `last` = (`cnt`==WIDTH-1).
- Space condition: `room` = !`ovalid` | `z_en`.
- Accept condition: `in_en` = `RST_N` & `in_rdy` & (!`last` | `room`).
  - Combinational paths from `in_rdy` and `z_en` into `in_en` are intended.
  - Upstream `y_rdy` must not depend on `y_en`.
- Bit accepted and !`last`:
  - `sr` <= {`in_data`, `sr[WIDTH-1:1]`};
  - `cnt` <= `cnt`+1.
- Bit accepted and `last` (word completes):
  - `obuf` <= {`in_data`, `sr[WIDTH-1:1]`};
  - `ovalid` <= 1;
  - `cnt` <= 0.
- Bit ordering: the first bit accepted in a word lands at `z_data[0]`; the WIDTH-th bit lands at `z_data[WIDTH-1]`.
- Dequeue with `z_en` & `ovalid` and no completion in the same cycle: `ovalid` <= 0.
- Simultaneous dequeue and completion: the new word replaces the old one and `ovalid` stays 1. No bubble is inserted and no word is lost.
- Full condition (`ovalid`=1, `last`=1, `z_en`=0):
  - `in_en`=0;
  - partial bits and `obuf` are held unchanged.
- `in_rdy`=0: no state change to `sr` or `cnt`. Gaps of any length between bits are allowed.
- `z_en` while `ovalid`=0: no effect.
- Reset (`RST_N`=0 at a clock edge):
  - `sr`=0, `cnt`=0, `obuf`=0, `ovalid`=0;
  - any partial word is discarded.
  - While `RST_N`=0, `in_en`=0 combinationally, so no upstream bit is consumed during reset.

## Timing
- Reset values of outputs: `in_en`=0, `z_rdy`=0, `z_data`=0, `fill`=0.
- Latency: `z_rdy` rises in the cycle after the edge that accepts the WIDTH-th bit.
- Throughput: one bit per cycle sustained. A full word every WIDTH cycles when the consumer dequeues each word before the next one completes.
- Backpressure: at most WIDTH-1 additional bits are absorbed while a word waits in `obuf`. The WIDTH-th bit stalls until `z_en` is asserted, and it is accepted in that same cycle.
- `fill` and `z_rdy` are registered. `in_en` is combinational.

## Test plan
- Reset: hold `RST_N`=0 for 2 cycles with `in_rdy`=1 -> `in_en`=0, `z_rdy`=0, `z_data`=0, `fill`=0 throughout.
- Single word: WIDTH=8, feed bits 1,0,1,1,0,0,1,0 on consecutive cycles with `z_en`=0 -> `fill` steps 1..7 then 0; `z_rdy`=1 with `z_data`=8'h4D one cycle after the 8th bit.
- Backpressure: keep `z_en`=0 and offer 16 bits (first word 8'hFF, second word all zeros).
  - `in_en` drops after 15 bits accepted, with `fill`=7 and `z_data`=8'hFF.
  - Pulse `z_en` for one cycle -> the 16th bit is accepted in that cycle; next cycle `z_rdy`=1, `z_data`=8'h00.
- Streaming: `in_rdy`=1 continuously and `z_en`=`z_rdy`, feeding words 8'hA5, 8'h3C, 8'h81 -> 24 consecutive `in_en` cycles with no gap; the three words appear in order.
- Reset mid-word: accept 5 bits, drive `RST_N`=0 for 1 cycle, then feed 8 bits forming 8'h5A -> `fill`=0 after reset; `z_data`=8'h5A with no residue from the discarded bits.
- Irregular source: toggle `in_rdy` pseudo-randomly (50%) while feeding 8'hC3 -> word is correct; `in_en` is never 1 while `in_rdy`=0.
